// File: rtl/matrix_mac_pkg.sv
// Shared types and helpers for the matrix MAC operand sequencer.
// Holds the FSM encoding, load-select codes and index-width helpers.
package matrix_mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    WAIT,
    EMIT,
    DONE
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int counter_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a row-major element index for a dim x dim matrix.
  function automatic int addr_width(input int dim);
    return counter_width(dim * dim);
  endfunction

endpackage

// File: rtl/matrix_mac_sequencer_if.sv
// Bundle of the sequencer's load port, control, MAC drive and result stream.
// The slave view belongs to the sequencer, the master view to its environment.
interface matrix_mac_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 4
);
  import matrix_mac_pkg::*;

  localparam int ADDR_W = addr_width(DIM);

  logic                  load_valid;
  logic                  load_ready;
  logic                  load_sel;
  logic [ADDR_W-1:0]     load_addr;
  logic [DATA_WIDTH-1:0] load_data;

  logic                  start;
  logic                  busy;
  logic                  done;

  logic                  mac_enable;
  logic                  mac_clear;
  logic [DATA_WIDTH-1:0] mac_operand_a;
  logic [DATA_WIDTH-1:0] mac_operand_b;
  logic [DATA_WIDTH-1:0] mac_result;

  logic                  res_valid;
  logic                  res_ready;
  logic [DATA_WIDTH-1:0] res_data;
  logic [ADDR_W-1:0]     res_index;

  modport slave (
    input  load_valid, load_sel, load_addr, load_data, start, mac_result, res_ready,
    output load_ready, busy, done, mac_enable, mac_clear, mac_operand_a, mac_operand_b,
           res_valid, res_data, res_index
  );

  modport master (
    output load_valid, load_sel, load_addr, load_data, start, mac_result, res_ready,
    input  load_ready, busy, done, mac_enable, mac_clear, mac_operand_a, mac_operand_b,
           res_valid, res_data, res_index
  );

endinterface

// File: rtl/matrix_operand_bank.sv
// Two DIM x DIM operand matrices with one shared write port and
// combinational reads of A[i][k] and B[k][j].
module matrix_operand_bank
  import matrix_mac_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIM        = 4,
  localparam int ADDR_W    = addr_width(DIM),
  localparam int CNT_W     = counter_width(DIM)
) (
  input  logic                  clock,
  input  logic                  write_en,
  input  logic                  write_sel,
  input  logic [ADDR_W-1:0]     write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [CNT_W-1:0]      row_i,
  input  logic [CNT_W-1:0]      col_j,
  input  logic [CNT_W-1:0]      step_k,
  output logic [DATA_WIDTH-1:0] operand_a,
  output logic [DATA_WIDTH-1:0] operand_b
);

  logic [DATA_WIDTH-1:0] mem_a [DIM*DIM];
  logic [DATA_WIDTH-1:0] mem_b [DIM*DIM];
  logic [ADDR_W-1:0]     addr_a;
  logic [ADDR_W-1:0]     addr_b;

  // NOTE: storage is deliberately left out of reset; its contents only
  // become meaningful once loaded, so only the write enable gates it.
  always_ff @(posedge clock) begin
    if (write_en && (int'(write_addr) < DIM * DIM)) begin
      if (write_sel == SEL_B) mem_b[write_addr] <= write_data;
      else                    mem_a[write_addr] <= write_data;
    end
  end

  assign addr_a    = ADDR_W'(int'(row_i) * DIM + int'(step_k));
  assign addr_b    = ADDR_W'(int'(step_k) * DIM + int'(col_j));
  assign operand_a = mem_a[addr_a];
  assign operand_b = mem_b[addr_b];

endmodule

// File: rtl/matrix_mac_sequencer.sv
// Operand-side controller for matrix_mac_unit: streams A rows against B columns
// into the MAC and emits the product matrix row-major on a valid/ready stream.
module matrix_mac_sequencer
  import matrix_mac_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int DIM         = 4,
  parameter int MAC_LATENCY = 1
) (
  input logic                   clock,
  input logic                   reset,
  matrix_mac_sequencer_if.slave bus
);

  localparam int CNT_W  = counter_width(DIM);
  localparam int ADDR_W = addr_width(DIM);
  localparam int WAIT_W = counter_width(MAC_LATENCY);

  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(DIM - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MAC_LATENCY - 1);

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      row_i;
  logic [CNT_W-1:0]      col_j;
  logic [CNT_W-1:0]      step_k;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [DATA_WIDTH-1:0] res_data_q;
  logic [ADDR_W-1:0]     res_index_q;
  logic [DATA_WIDTH-1:0] bank_a;
  logic [DATA_WIDTH-1:0] bank_b;
  logic                  load_accept;
  logic                  last_element;

  // Writes are only honoured in IDLE, so a multiply always sees a frozen bank.
  assign load_accept  = bus.load_valid && (state == IDLE);
  assign last_element = (row_i == LAST_IDX) && (col_j == LAST_IDX);

  matrix_operand_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .DIM        (DIM)
  ) u_bank (
    .clock      (clock),
    .write_en   (load_accept),
    .write_sel  (bus.load_sel),
    .write_addr (bus.load_addr),
    .write_data (bus.load_data),
    .row_i      (row_i),
    .col_j      (col_j),
    .step_k     (step_k),
    .operand_a  (bank_a),
    .operand_b  (bank_b)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = CLEAR;
      CLEAR:   state_next = FEED;
      FEED:    if (step_k == LAST_IDX) state_next = WAIT;
      WAIT:    if (wait_cnt == LAST_WAIT) state_next = EMIT;
      EMIT:    if (bus.res_ready) state_next = last_element ? DONE : CLEAR;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_i       <= '0;
      col_j       <= '0;
      step_k      <= '0;
      wait_cnt    <= '0;
      res_data_q  <= '0;
      res_index_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            row_i <= '0;
            col_j <= '0;
          end
        end
        CLEAR: begin
          step_k   <= '0;
          wait_cnt <= '0;
        end
        FEED: step_k <= step_k + CNT_W'(1);
        WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            res_data_q  <= bus.mac_result;
            res_index_q <= ADDR_W'(int'(row_i) * DIM + int'(col_j));
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        EMIT: begin
          if (bus.res_ready) begin
            if (col_j == LAST_IDX) begin
              col_j <= '0;
              row_i <= last_element ? '0 : row_i + CNT_W'(1);
            end else begin
              col_j <= col_j + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output is defaulted first so no state leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    bus.load_ready    = 1'b0;
    bus.mac_clear     = 1'b0;
    bus.mac_enable    = 1'b0;
    bus.mac_operand_a = '0;
    bus.mac_operand_b = '0;
    bus.res_valid     = 1'b0;
    bus.done          = 1'b0;
    case (state)
      IDLE:  bus.load_ready = 1'b1;
      CLEAR: bus.mac_clear  = 1'b1;
      FEED: begin
        bus.mac_enable    = 1'b1;
        bus.mac_operand_a = bank_a;
        bus.mac_operand_b = bank_b;
      end
      EMIT:    bus.res_valid = 1'b1;
      DONE:    bus.done      = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy      = (state != IDLE);
  assign bus.res_data  = res_data_q;
  assign bus.res_index = res_index_q;

endmodule

// File: tb/tb_matrix_mac_sequencer.sv
// Directed bench for matrix_mac_sequencer with a behavioural latency-1 MAC.
// Covers reset, multiply results, cycle timing, backpressure, busy loads and reset abort.
module tb_matrix_mac_sequencer;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int NN = N * N;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] ref_a [NN];
  logic [DW-1:0] ref_b [NN];
  logic [DW-1:0] exp_c [NN];
  logic [DW-1:0] acc;

  matrix_mac_sequencer_if #(.DATA_WIDTH(DW), .DIM(N)) bus ();

  matrix_mac_sequencer #(
    .DATA_WIDTH  (DW),
    .DIM         (N),
    .MAC_LATENCY (1)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural MAC: clear zeroes, enable accumulates, result visible one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              acc <= '0;
    else if (bus.mac_clear)  acc <= '0;
    else if (bus.mac_enable) acc <= acc + bus.mac_operand_a * bus.mac_operand_b;
  end
  assign bus.mac_result = acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic void compute_expected();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        logic [DW-1:0] s;
        s = '0;
        for (int k = 0; k < N; k++) s = s + ref_a[i*N+k] * ref_b[k*N+j];
        exp_c[i*N+j] = s;
      end
    end
  endfunction

  task automatic load_all();
    for (int s = 0; s < 2; s++) begin
      for (int n = 0; n < NN; n++) begin
        @(negedge clk);
        bus.load_valid = 1'b1;
        bus.load_sel   = s[0];
        bus.load_addr  = 4'(n);
        bus.load_data  = (s == 0) ? ref_a[n] : ref_b[n];
      end
    end
    @(negedge clk);
    bus.load_valid = 1'b0;
  endtask

  // Starts a multiply and checks every result, the timing and the done pulse.
  task automatic run_mult(input int stall_idx, input bit intrude, input bit same_load);
    int n_res = 0, n_done = 0, n_en = 0, stall_left = 5;
    int first_clear = -1, second_clear = -1, first_en = -1, first_valid = -1;
    int done_cyc = -1, en_before_valid = 0;
    bit intruded = 1'b0;
    logic [DW-1:0] held_data;
    logic [3:0]    held_idx;
    compute_expected();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    if (same_load) begin
      bus.load_valid = 1'b1;
      bus.load_sel   = 1'b0;
      bus.load_addr  = 4'd0;
      bus.load_data  = ref_a[0];
    end
    @(negedge clk);
    for (int c = 1; c <= 400; c++) begin
      bus.start      = 1'b0;
      bus.load_valid = 1'b0;
      if (bus.mac_clear) begin
        if (first_clear < 0) first_clear = c;
        else if (second_clear < 0) second_clear = c;
      end
      if (bus.mac_enable) begin
        n_en++;
        if (first_en < 0) first_en = c;
        if (first_valid < 0) en_before_valid++;
        if (intrude && !intruded) begin
          check("load_ready_in_feed", bus.load_ready, 0);
          bus.load_valid = 1'b1;
          bus.load_sel   = 1'b0;
          bus.load_addr  = 4'd0;
          bus.load_data  = 8'hAA;
          bus.start      = 1'b1;
          intruded       = 1'b1;
        end
      end
      if (bus.done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (bus.res_valid) begin
        if (first_valid < 0) first_valid = c;
        if (int'(bus.res_index) == stall_idx && stall_left > 0) begin
          if (stall_left == 5) begin
            held_data = bus.res_data;
            held_idx  = bus.res_index;
          end else begin
            check("stall_data_stable", bus.res_data, held_data);
            check("stall_index_stable", bus.res_index, held_idx);
          end
          check("stall_no_enable", bus.mac_enable, 0);
          bus.res_ready = 1'b0;
          stall_left--;
        end else begin
          bus.res_ready = 1'b1;
          if (n_res < NN) begin
            check($sformatf("res_index[%0d]", n_res), bus.res_index, n_res);
            check($sformatf("res_data[%0d]", n_res), bus.res_data, exp_c[n_res]);
          end else begin
            check("result_count_overrun", n_res + 1, NN);
          end
          n_res++;
        end
      end
      if (done_cyc >= 0 && c >= done_cyc + 4) break;
      @(negedge clk);
    end
    check("result_count", n_res, NN);
    check("done_pulses", n_done, 1);
    check("enable_cycles", n_en, NN * N);
    check("first_clear_cycle", first_clear, 1);
    check("first_enable_cycle", first_en, 2);
    check("enables_first_element", en_before_valid, N);
    check("first_valid_cycle", first_valid, 7);
    check("second_clear_cycle", second_clear, 8);
    check("done_cycle", done_cyc, (stall_idx >= 0) ? 118 : 113);
    check("idle_after_done", bus.busy, 0);
    if (intrude) check("intrusion_seen", intruded, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.load_valid = 1'b0;
    bus.load_sel   = 1'b0;
    bus.load_addr  = '0;
    bus.load_data  = '0;
    bus.start      = 1'b0;
    bus.res_ready  = 1'b1;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_load_ready", bus.load_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_mac_enable", bus.mac_enable, 0);
    check("rst_mac_clear", bus.mac_clear, 0);
    check("rst_operand_a", bus.mac_operand_a, 0);
    check("rst_operand_b", bus.mac_operand_b, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_index", bus.res_index, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Identity x (1..16): results are 1..16 in order
    for (int n = 0; n < NN; n++) begin
      ref_a[n] = (n % (N + 1) == 0) ? 8'd1 : 8'd0;
      ref_b[n] = 8'(n + 1);
    end
    load_all();
    run_mult(-1, 1'b0, 1'b0);

    // Backpressure on element 3: A = 1..16, B all 2 -> rows 20, 52, 84, 116
    for (int n = 0; n < NN; n++) begin
      ref_a[n] = 8'(n + 1);
      ref_b[n] = 8'd2;
    end
    load_all();
    run_mult(3, 1'b0, 1'b0);

    // Load and second start while busy are dropped: A = 1..16, B = identity
    for (int n = 0; n < NN; n++) begin
      ref_a[n] = 8'(n + 1);
      ref_b[n] = (n % (N + 1) == 0) ? 8'd1 : 8'd0;
    end
    load_all();
    run_mult(-1, 1'b1, 1'b0);

    // Same-edge A[0][0] = 5 and start: first row becomes 5, 10, 15, 20
    for (int n = 0; n < NN; n++) begin
      ref_a[n] = (n % (N + 1) == 0) ? 8'd1 : 8'd0;
      ref_b[n] = 8'(n + 1);
    end
    load_all();
    ref_a[0] = 8'd5;
    run_mult(-1, 1'b0, 1'b1);

    // Reset during FEED aborts asynchronously with no done pulse
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 20 && !bus.mac_enable; c++) @(negedge clk);
    check("reached_feed", bus.mac_enable, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mac_enable", bus.mac_enable, 0);
    check("abort_res_valid", bus.res_valid, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_load_ready", bus.load_ready, 1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abort_no_done", bus.done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", bus.busy, 0);
    check("post_reset_no_done", bus.done, 0);

    // Recovery run with wrapping sums: A = 16..1, B = 1..16
    for (int n = 0; n < NN; n++) begin
      ref_a[n] = 8'(NN - n);
      ref_b[n] = 8'(n + 1);
    end
    load_all();
    run_mult(-1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
